multfa_bist: RTL
================

Name: multfa_bist

Overview:
- On-chip host for the full-adder multiplier: drives operand pairs into the multiplier's input bus and reads back its product bus.
- Exhaustive self-test: sweeps every unsigned OP_W x OP_W operand pair and compares each product against an internal golden product.
- Reports pass/fail, error count and the first failing vector.
- Sits beside the multiplier core inside the tt_um wrapper so silicon can be checked without external pattern generation.

Parameters:
- OP_W, 4, operand width; the vector index is 2*OP_W bits.
- LAT, 0, multiplier latency in clock cycles from operand change to product valid (0 = combinational).
- ERR_W, 8, error-counter width; the counter saturates.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; starts a sweep from IDLE or DONE
- op_o  out  2*OP_W  operands to the multiplier: {a, b}, with a = op_o[2*OP_W-1:OP_W] and b = op_o[OP_W-1:0]
- prod_i  in  2*OP_W  product returned by the multiplier
- busy  out  1  sweep in progress
- done  out  1  sweep complete; held until the next start
- pass  out  1  done and err_cnt == 0
- err_cnt  out  ERR_W  number of mismatching vectors, saturating at all-ones
- fail_idx  out  2*OP_W  index of the first mismatching vector; 0 if none
- fail_seen  out  1  at least one mismatch in the current sweep

Behaviour:
- Reset: all outputs are 0; the FSM enters IDLE; the vector index and wait counter are 0.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE after the final vector (index = all-ones) is checked.
  - DONE -> RUN on start.
- Entering RUN: clear err_cnt, fail_idx and fail_seen; set the index to 0; op_o <= 0; busy = 1; done = 0.
- Vector timing:
  - Vector k is presented on op_o at edge E_k.
  - prod_i is sampled at edge E_k + (LAT+1).
  - The same edge loads vector k+1 onto op_o, so one vector completes every LAT+1 cycles.
  - A full sweep takes 2^(2*OP_W)*(LAT+1) cycles after the start edge.
- Golden product = a*b, unsigned, 2*OP_W bits (never overflows).
- On mismatch:
  - err_cnt increments unless it is already all-ones.
  - If fail_seen = 0, capture the index into fail_idx and set fail_seen.
- Last vector: after the all-ones index is checked, go to DONE; busy = 0, done = 1; op_o holds its last value; the index does not wrap into a new sweep.
- start while in RUN is ignored.
- prod_i is ignored outside the sampling edges.
- rst_n asserted mid-sweep aborts immediately to the reset values; no partial results are retained.
- pass is combinational: done & (err_cnt == 0).

Optional Feature:
- Macro: MULTFA_BIST_MISR_EN.
- Defined:
  - Adds output port sig_o [15:0] and a 16-bit Galois MISR.
  - Polynomial x^16+x^14+x^13+x^11+1 (mask 0xB400), seed 0xFFFF loaded on entry to RUN.
  - At each sampling edge: shift one step, then XOR in prod_i zero-extended to 16 bits.
  - sig_o is valid when done and is 0 after reset.
- Undefined: no sig_o port, no MISR logic; behaviour is otherwise identical.

Decomposition:
- Package multfa_pkg: OP_W default, LAT default, state enum {IDLE, RUN, DONE}, MISR polynomial and seed constants, and a golden_mult function.
- One natural sub-module, multfa_misr (16-bit MISR with load/enable), instantiated only under MULTFA_BIST_MISR_EN.

Test Plan:
- Pass sweep: OP_W=4, LAT=0, golden bench model as DUT; pulse start -> done after 256 cycles, pass=1, err_cnt=0, fail_seen=0.
- Stuck bit: DUT prod bit0 stuck at 0 -> err_cnt=64 (a odd, b odd), fail_idx=0x11, pass=0.
- Single fault: corrupt only vector 0xA5 -> err_cnt=1, fail_idx=0xA5; saturation check with ERR_W=4 plus stuck bit0 -> err_cnt=15.
- Latency: LAT=2 with a 2-stage registered model -> done after 768 cycles, pass=1; same model run with LAT=0 -> err_cnt>0.
- Control: start pulsed mid-RUN ignored (completion cycle unchanged); rst_n low at cycle 100 -> all outputs 0, IDLE; a new start runs a clean sweep; restart from DONE clears counters.
- MISR (macro defined): sig_o equals the bench's reference MISR over the 256 golden products; flipping one product bit changes sig_o.

Source files
------------

// File: rtl/multfa_pkg.sv
// Shared types and constants for the multiplier self-test host: default sizes,
// sequencer states, MISR polynomial/seed and the reference product function.
package multfa_pkg;

    localparam int OP_W_DEF  = 4;
    localparam int LAT_DEF   = 0;
    localparam int ERR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] MISR_POLY = 16'hB400;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Operands up to 16 bits; the 32-bit result cannot overflow.
    function automatic logic [31:0] golden_mult(input logic [15:0] a, input logic [15:0] b);
        return {16'h0000, a} * {16'h0000, b};
    endfunction

endpackage

// File: rtl/multfa_misr.sv
// 16-bit Galois MISR: load_i reseeds, en_i shifts one step then folds in dat_i.
// Single-cycle update, no backpressure; signature is 0 out of reset.
module multfa_misr
    import multfa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [15:0] dat_i,
    output logic [15:0] sig_o
);

    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = MISR_SEED;
        end else if (en_i) begin
            sig_d = ({1'b0, sig_q[15:1]} ^ (sig_q[0] ? MISR_POLY : 16'h0000)) ^ dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/multfa_bist.sv
// Exhaustive self-test host for the multiplier: one vector per LAT+1 cycles, full sweep 2^(2*OP_W)*(LAT+1) cycles.
// No backpressure; start is ignored while a sweep runs. MULTFA_BIST_MISR_EN adds the sig_o product signature.
module multfa_bist
    import multfa_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [2*OP_W-1:0]   op_o,
    input  logic [2*OP_W-1:0]   prod_i,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_cnt,
    output logic [2*OP_W-1:0]   fail_idx,
    output logic                fail_seen
`ifdef MULTFA_BIST_MISR_EN
    ,
    output logic [15:0]         sig_o
`endif
);

    localparam int                IDX_W    = 2 * OP_W;
    localparam int                WAIT_W   = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [WAIT_W-1:0] LAT_V    = WAIT_W'(LAT);
    localparam logic [IDX_W-1:0]  IDX_LAST = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
    logic               fail_seen_q, fail_seen_d;
    logic [IDX_W-1:0]   gold;
    logic               mismatch;

    // The index itself is the operand pair {a, b}, so op_o needs no extra register.
    assign gold     = IDX_W'(golden_mult(16'(idx_q[IDX_W-1:OP_W]), 16'(idx_q[OP_W-1:0])));
    assign mismatch = (prod_i != gold);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        err_d       = err_q;
        fail_idx_d  = fail_idx_q;
        fail_seen_d = fail_seen_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    idx_d       = '0;
                    wait_d      = '0;
                    err_d       = '0;
                    fail_idx_d  = '0;
                    fail_seen_d = 1'b0;
                end
            end
            RUN: begin
                if (wait_q == LAT_V) begin
                    wait_d = '0;
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fail_seen_q) begin
                            fail_idx_d  = idx_q;
                            fail_seen_d = 1'b1;
                        end
                    end
                    // Last vector parks the index so op_o keeps its final value.
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            err_q       <= '0;
            fail_idx_q  <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            fail_idx_q  <= fail_idx_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign op_o      = idx_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == '0);
    assign err_cnt   = err_q;
    assign fail_idx  = fail_idx_q;
    assign fail_seen = fail_seen_q;

`ifdef MULTFA_BIST_MISR_EN
    logic misr_load, misr_en;

    assign misr_load = (state_q != RUN) && start;
    assign misr_en   = (state_q == RUN) && (wait_q == LAT_V);

    multfa_misr u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (misr_load),
        .en_i   (misr_en),
        .dat_i  (16'(prod_i)),
        .sig_o  (sig_o)
    );
`endif

endmodule
